// File: rtl/hash_pkg.sv
// hash_pkg: byte type, FSM states and rotate helpers shared by the hash chain engine
package hash_pkg;
    typedef logic [7:0] byte_t;
    typedef enum logic [1:0] {IDLE, WAIT_BLK, ROUND} state_t;
    function automatic byte_t rotl8(input byte_t b, input logic [2:0] a);
        logic [15:0] w;
        w = {b, b} << a;
        return w[15:8];
    endfunction
    function automatic logic [2:0] rot_amt(input int r);
        return 3'(1 + r % 7);
    endfunction
endpackage

// File: rtl/hash_round.sv
// hash_round: one combinational mixing round on working state h with message block m
module hash_round
    import hash_pkg::*;
#(
    parameter int N_BYTES = 4,
    parameter int RW      = 4
) (
    input  logic [N_BYTES*8-1:0] i_h,
    input  logic [N_BYTES*8-1:0] i_m,
    input  logic [RW-1:0]        i_r,
    output logic [N_BYTES*8-1:0] o_h
);
    localparam int IW = $clog2(N_BYTES);
    typedef logic [0:N_BYTES-1][7:0] block_t;
    block_t w_h, w_m, w_t, w_o;
    logic [IW-1:0] w_idx;
    assign w_h = i_h;
    assign w_m = i_m;
    assign o_h = w_o;
    always_comb begin
        w_t   = '0;
        w_o   = '0;
        w_idx = '0;
        for (int i = 0; i < N_BYTES; i++) begin
            w_idx  = IW'((i + int'(i_r)) % N_BYTES);
            w_t[i] = rotl8(w_h[i] ^ w_m[w_idx], rot_amt(int'(i_r)));
        end
        for (int i = 0; i < N_BYTES; i++)
            w_o[i] = w_t[i] + w_t[IW'((i + 1) % N_BYTES)];
    end
endmodule

// File: rtl/hash_chain_engine.sv
// hash_chain_engine: multi-block chained hash, one round per clock, digest with done pulse
module hash_chain_engine
    import hash_pkg::*;
#(
    parameter int N_BYTES = 4,
    parameter int ROUNDS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic [N_BYTES*8-1:0] i_iv,
    input  logic                 i_blk_valid,
    output logic                 o_blk_ready,
    input  logic [N_BYTES*8-1:0] i_blk_data,
    input  logic                 i_blk_last,
    output logic                 o_busy,
    output logic [N_BYTES*8-1:0] o_digest,
    output logic                 o_done
);
    localparam int CW = $clog2(ROUNDS) + 1;
    state_t               r_state;
    logic [N_BYTES*8-1:0] r_chain, r_h, r_m, r_digest, w_h_next;
    logic                 r_last, r_done;
    logic [CW-1:0]        r_ctr;

    hash_round #(.N_BYTES(N_BYTES), .RW(CW)) u_round (
        .i_h(r_h),
        .i_m(r_m),
        .i_r(r_ctr),
        .o_h(w_h_next)
    );

    assign o_blk_ready = r_state == WAIT_BLK;
    assign o_busy      = r_state != IDLE;
    assign o_digest    = r_digest;
    assign o_done      = r_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_chain  <= '0;
            r_h      <= '0;
            r_m      <= '0;
            r_digest <= '0;
            r_last   <= 1'b0;
            r_done   <= 1'b0;
            r_ctr    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (i_start) begin
                    r_chain <= i_iv;
                    r_state <= WAIT_BLK;
                end
                WAIT_BLK: if (i_blk_valid) begin
                    r_m     <= i_blk_data;
                    r_h     <= r_chain;
                    r_last  <= i_blk_last;
                    r_ctr   <= '0;
                    r_state <= ROUND;
                end
                ROUND: begin
                    r_h   <= w_h_next;
                    r_ctr <= r_ctr + CW'(1);
                    // r_chain still holds the block's input chain here, giving the feed-forward
                    if (r_ctr == CW'(ROUNDS - 1)) begin
                        r_chain <= w_h_next ^ r_chain;
                        r_state <= r_last ? IDLE : WAIT_BLK;
                        if (r_last) begin
                            r_digest <= w_h_next ^ r_chain;
                            r_done   <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hash_chain_engine.sv
// tb_hash_chain_engine: scoreboard bench for the R=8 engine plus a directed R=1 instance
module tb_hash_chain_engine;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        start, bv, bl, rdy, busy, done;
    logic [31:0] iv, bd, dig;
    logic        s1, bv1, bl1, rdy1, busy1, done1;
    logic [31:0] iv1, bd1, dig1;

    hash_chain_engine #(.N_BYTES(4), .ROUNDS(8)) dut (
        .clk(clk), .rst(rst), .i_start(start), .i_iv(iv), .i_blk_valid(bv),
        .o_blk_ready(rdy), .i_blk_data(bd), .i_blk_last(bl), .o_busy(busy),
        .o_digest(dig), .o_done(done)
    );
    hash_chain_engine #(.N_BYTES(4), .ROUNDS(1)) dut1 (
        .clk(clk), .rst(rst), .i_start(s1), .i_iv(iv1), .i_blk_valid(bv1),
        .o_blk_ready(rdy1), .i_blk_data(bd1), .i_blk_last(bl1), .o_busy(busy1),
        .o_digest(dig1), .o_done(done1)
    );

    int n_cmp = 0, n_err = 0;
    int cyc = 0, done_cnt = 0, done_cyc = 0, busy_cnt = 0, rdy_cnt = 0;
    logic [31:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] rl(input logic [7:0] x, input int a);
        int v;
        v = int'(x);
        return 8'(((v << a) | (v >> (8 - a))) & 255);
    endfunction

    function automatic logic [31:0] blk(input logic [31:0] c, input logic [31:0] m, input int rounds);
        logic [7:0] h[4], mb[4], t[4];
        for (int i = 0; i < 4; i++) begin
            h[i]  = c[31-8*i -: 8];
            mb[i] = m[31-8*i -: 8];
        end
        for (int r = 0; r < rounds; r++) begin
            for (int i = 0; i < 4; i++) t[i] = rl(h[i] ^ mb[(i + r) % 4], 1 + r % 7);
            for (int i = 0; i < 4; i++) h[i] = t[i] + t[(i + 1) % 4];
        end
        return {h[0], h[1], h[2], h[3]} ^ c;
    endfunction

    localparam logic [31:0] IV3 = 32'h34550F14;
    localparam logic [31:0] B0 = 32'h01020304, B1 = 32'hFFEEDDCC, B2 = 32'h00000000;

    always @(negedge clk) begin
        if (!rst) begin
            if (busy) busy_cnt++;
            if (rdy) rdy_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_done: got %h expected no completion", dig);
                end else chk("digest", dig, exp_q.pop_front());
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start(input logic [31:0] v);
        start = 1'b1;
        iv    = v;
        step();
        start = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!rdy && n < 50) begin
            step();
            n++;
        end
        if (!rdy) chk("ready_timeout", 32'(rdy), 32'd1);
    endtask

    task automatic send_block(input logic [31:0] d, input logic l, output int hs);
        bv = 1'b1;
        bd = d;
        bl = l;
        wait_ready();
        hs = cyc;
        step();
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 100) begin
            step();
            n++;
        end
        if (!done) chk("done_timeout", 32'(done), 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got no end expected summary");
        $fatal(1);
    end

    initial begin
        int h0, h1, h2, b0, r0, d0, n;
        logic [31:0] g3, prev;
        g3 = blk(blk(blk(IV3, B0, 8), B1, 8), B2, 8);
        rst = 1'b1;
        {start, bv, bl, s1, bv1, bl1} = '0;
        {iv, bd, iv1, bd1} = '0;
        step(3);
        chk("rst_ready", 32'(rdy), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_digest", dig, 0);
        chk("rst_digest_r1", dig1, 0);
        rst = 1'b0;
        step();

        // R=1 single block, hand-computed digest
        s1 = 1'b1;
        step();
        s1  = 1'b0;
        bv1 = 1'b1;
        bd1 = 32'h01000000;
        bl1 = 1'b1;
        chk("r1_ready", 32'(rdy1), 1);
        h0 = cyc;
        step();
        bv1 = 1'b0;
        n = 0;
        while (!done1 && n < 20) begin
            step();
            n++;
        end
        chk("r1_latency", 32'(cyc - h0), 2);
        chk("r1_digest", dig1, 32'h02000002);
        step();
        chk("r1_done_pulse", 32'(done1), 0);

        // all-zero message, busy window
        exp_q.push_back(32'h00000000);
        b0 = busy_cnt;
        do_start(32'h0);
        send_block(32'h0, 1'b1, h0);
        bv = 1'b0;
        wait_done();
        step();
        chk("busy_cycles", 32'(busy_cnt - b0), 9);

        // three blocks, valid held high
        exp_q.push_back(g3);
        d0 = done_cnt;
        r0 = rdy_cnt;
        do_start(IV3);
        send_block(B0, 1'b0, h0);
        send_block(B1, 1'b0, h1);
        send_block(B2, 1'b1, h2);
        bv = 1'b0;
        wait_done();
        step();
        chk("spacing_01", 32'(h1 - h0), 9);
        chk("spacing_12", 32'(h2 - h1), 9);
        chk("ready_pulses", 32'(rdy_cnt - r0), 3);
        chk("msg_latency", 32'(done_cyc - h0), 27);
        chk("done_once", 32'(done_cnt - d0), 1);

        // same message with 5-cycle stalls between blocks
        exp_q.push_back(g3);
        do_start(IV3);
        send_block(B0, 1'b0, h0);
        bv = 1'b0;
        wait_ready();
        step(5);
        chk("stall_busy", 32'(busy), 1);
        chk("stall_ready", 32'(rdy), 1);
        send_block(B1, 1'b0, h1);
        bv = 1'b0;
        wait_ready();
        step(5);
        send_block(B2, 1'b1, h2);
        bv = 1'b0;
        wait_done();
        step();

        // start during ROUND ignored; back-to-back start on the done cycle
        exp_q.push_back(blk(32'hA5A5_0F0F, 32'h1234_5678, 8));
        do_start(32'hA5A5_0F0F);
        send_block(32'h1234_5678, 1'b1, h0);
        bv = 1'b0;
        step(2);
        start = 1'b1;
        iv    = 32'hFFFF_FFFF;
        step();
        start = 1'b0;
        wait_done();
        prev = dig;
        exp_q.push_back(blk(32'h0BAD_F00D, 32'hCAFE_0001, 8));
        do_start(32'h0BAD_F00D);
        chk("b2b_busy", 32'(busy), 1);
        chk("digest_hold", dig, prev);
        send_block(32'hCAFE_0001, 1'b1, h0);
        bv = 1'b0;
        wait_done();
        step();

        // blk_valid in IDLE has no effect
        bv = 1'b1;
        bd = 32'hDEAD_BEEF;
        step(3);
        chk("idle_ready", 32'(rdy), 0);
        chk("idle_busy", 32'(busy), 0);
        bv = 1'b0;

        // reset in the middle of block 2, then a fresh message
        do_start(IV3);
        send_block(B0, 1'b0, h0);
        send_block(B1, 1'b0, h1);
        bv = 1'b0;
        step(3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_ready", 32'(rdy), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_digest", dig, 0);
        exp_q.push_back(g3);
        do_start(IV3);
        send_block(B0, 1'b0, h0);
        send_block(B1, 1'b0, h1);
        send_block(B2, 1'b1, h2);
        bv = 1'b0;
        wait_done();
        step(3);
        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
